// File: rtl/ibuffer_warp.sv
// rtl/ibuffer_warp.sv - per-warp instruction buffer feeding scoreboard and issue arbiter
// Holds memory heads across replays until completion releases their scoreboard slot.
module ibuffer_warp #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IF_Valid,
  output logic               IF_Ready,
  input  logic [INSTR_W-1:0] IF_Instr,
  input  logic [4:0]         IF_Src1,
  input  logic [4:0]         IF_Src2,
  input  logic [4:0]         IF_Dst,
  input  logic               IF_Src1_Valid,
  input  logic               IF_Src2_Valid,
  input  logic               IF_Dst_Valid,
  input  logic               IF_IsMem,
  output logic [4:0]         Src1,
  output logic [4:0]         Src2,
  output logic [4:0]         Dst,
  output logic               Src1_Valid,
  output logic               Src2_Valid,
  output logic               Dst_Valid,
  input  logic               Scb_Dependent,
  input  logic               Scb_Full,
  input  logic [1:0]         ScbID_Scb_IB,
  output logic               RP_Grt,
  output logic               Replay_Complete,
  output logic [1:0]         Replay_Complete_ScbID,
  output logic               Issue_Req,
  output logic               Issue_Replay,
  input  logic               Issue_Grt,
  output logic [INSTR_W-1:0] Issue_Instr,
  output logic [1:0]         Issue_ScbID,
  input  logic               Mem_Replay,
  input  logic               Mem_Done,
  input  logic               Flush,
  output logic               Empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {H_READY, H_WAIT, H_REPLAY} head_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [4:0]         src1;
    logic [4:0]         src2;
    logic [4:0]         dst;
    logic               src1_v;
    logic               src2_v;
    logic               dst_v;
    logic               is_mem;
  } entry_t;

  entry_t        buf_q [DEPTH];
  entry_t        buf_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    saved_id_q, saved_id_d;
  head_state_e   state_q, state_d;
  entry_t        head;
  logic          push, pop, grant;

  assign head     = buf_q[rd_ptr_q];
  assign Empty    = (count_q == '0);
  // count never exceeds DEPTH, so its MSB alone marks full
  assign IF_Ready = !count_q[AW];
  assign push     = IF_Valid && IF_Ready && !Flush;
  assign grant    = Issue_Req && Issue_Grt;

  assign Src1                  = head.src1;
  assign Src2                  = head.src2;
  assign Dst                   = head.dst;
  assign Src1_Valid            = head.src1_v && !Empty;
  assign Src2_Valid            = head.src2_v && !Empty;
  assign Dst_Valid             = head.dst_v && !Empty;
  assign Issue_Instr           = head.instr;
  assign Replay_Complete_ScbID = saved_id_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= H_READY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    saved_id_d = saved_id_q;
    case (state_q)
      H_READY: if (RP_Grt && head.is_mem) begin
        state_d    = H_WAIT;
        saved_id_d = ScbID_Scb_IB;
      end
      H_WAIT: begin
        if (Mem_Done)        state_d = H_READY;
        else if (Mem_Replay) state_d = H_REPLAY;
      end
      H_REPLAY: if (grant) state_d = H_WAIT;
      default:  state_d = H_READY;
    endcase
  end

  // Replays bypass hazard checks: the head already owns its scoreboard entry
  always_comb begin
    Issue_Req       = 1'b0;
    Issue_Replay    = 1'b0;
    Issue_ScbID     = saved_id_q;
    RP_Grt          = 1'b0;
    Replay_Complete = 1'b0;
    pop             = 1'b0;
    case (state_q)
      H_READY: begin
        Issue_Req   = !Empty && !Scb_Dependent && !Scb_Full;
        Issue_ScbID = ScbID_Scb_IB;
        RP_Grt      = Issue_Req && Issue_Grt;
        pop         = RP_Grt && !head.is_mem;
      end
      H_WAIT: begin
        Replay_Complete = Mem_Done;
        pop             = Mem_Done;
      end
      H_REPLAY: begin
        Issue_Req    = 1'b1;
        Issue_Replay = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    buf_d    = buf_q;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      buf_d[wr_ptr_q].instr  = IF_Instr;
      buf_d[wr_ptr_q].src1   = IF_Src1;
      buf_d[wr_ptr_q].src2   = IF_Src2;
      buf_d[wr_ptr_q].dst    = IF_Dst;
      buf_d[wr_ptr_q].src1_v = IF_Src1_Valid;
      buf_d[wr_ptr_q].src2_v = IF_Src2_Valid;
      buf_d[wr_ptr_q].dst_v  = IF_Dst_Valid;
      buf_d[wr_ptr_q].is_mem = IF_IsMem;
    end
    // An in-flight memory head survives a flush so its slot can still be released
    if (Flush) begin
      if (state_d != H_READY) begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = rd_ptr_q + AW'(1);
        count_d  = CW'(1);
      end else begin
        wr_ptr_d = rd_ptr_d;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q      <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      saved_id_q <= '0;
    end else begin
      buf_q      <= buf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      saved_id_q <= saved_id_d;
    end
  end
endmodule

// File: tb/tb_ibuffer_warp.sv
// tb/tb_ibuffer_warp.sv - directed and randomized checks of ibuffer_warp against a queue model
module tb_ibuffer_warp;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IF_Valid, IF_Ready, IF_Src1_Valid, IF_Src2_Valid, IF_Dst_Valid, IF_IsMem;
  logic [31:0] IF_Instr, Issue_Instr;
  logic [4:0]  IF_Src1, IF_Src2, IF_Dst, Src1, Src2, Dst;
  logic        Src1_Valid, Src2_Valid, Dst_Valid;
  logic        Scb_Dependent, Scb_Full, RP_Grt, Replay_Complete;
  logic [1:0]  ScbID_Scb_IB, Replay_Complete_ScbID, Issue_ScbID;
  logic        Issue_Req, Issue_Replay, Issue_Grt, Mem_Replay, Mem_Done, Flush, Empty;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ibuffer_warp #(.DEPTH(DEPTH), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst),
    .IF_Valid(IF_Valid), .IF_Ready(IF_Ready), .IF_Instr(IF_Instr),
    .IF_Src1(IF_Src1), .IF_Src2(IF_Src2), .IF_Dst(IF_Dst),
    .IF_Src1_Valid(IF_Src1_Valid), .IF_Src2_Valid(IF_Src2_Valid), .IF_Dst_Valid(IF_Dst_Valid),
    .IF_IsMem(IF_IsMem),
    .Src1(Src1), .Src2(Src2), .Dst(Dst),
    .Src1_Valid(Src1_Valid), .Src2_Valid(Src2_Valid), .Dst_Valid(Dst_Valid),
    .Scb_Dependent(Scb_Dependent), .Scb_Full(Scb_Full), .ScbID_Scb_IB(ScbID_Scb_IB),
    .RP_Grt(RP_Grt), .Replay_Complete(Replay_Complete), .Replay_Complete_ScbID(Replay_Complete_ScbID),
    .Issue_Req(Issue_Req), .Issue_Replay(Issue_Replay), .Issue_Grt(Issue_Grt),
    .Issue_Instr(Issue_Instr), .Issue_ScbID(Issue_ScbID),
    .Mem_Replay(Mem_Replay), .Mem_Done(Mem_Done), .Flush(Flush), .Empty(Empty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue plus "head issued" / "replay pending" flags
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  s1, s2, d;
    logic        v1, v2, vd, mem;
  } ent_t;

  ent_t       q[$];
  bit         m_live = 0, m_issued = 0, m_replay = 0;
  logic [1:0] m_saved = 0;
  bit         e_empty, e_ready, e_req, e_rpl, e_grant, e_rpgrt, e_rc;
  logic [1:0] e_id;

  task automatic model_eval();
    e_empty = (q.size() == 0);
    e_ready = (q.size() < DEPTH);
    if (!m_issued) begin
      e_req = !e_empty && !Scb_Dependent && !Scb_Full;
      e_rpl = 1'b0;
      e_id  = ScbID_Scb_IB;
    end else begin
      e_req = m_replay;
      e_rpl = m_replay;
      e_id  = m_saved;
    end
    e_grant = e_req && Issue_Grt;
    e_rpgrt = e_grant && !m_issued;
    e_rc    = m_issued && !m_replay && Mem_Done;
  endtask

  always @(negedge clk) begin
    #1;
    model_eval();
    if (m_live) begin
      chk("Empty", 32'(Empty), 32'(e_empty));
      chk("IF_Ready", 32'(IF_Ready), 32'(e_ready));
      chk("Issue_Req", 32'(Issue_Req), 32'(e_req));
      chk("Issue_Replay", 32'(Issue_Replay), 32'(e_rpl));
      chk("RP_Grt", 32'(RP_Grt), 32'(e_rpgrt));
      chk("Replay_Complete", 32'(Replay_Complete), 32'(e_rc));
      if (e_req) chk("Issue_ScbID", 32'(Issue_ScbID), 32'(e_id));
      if (e_rc)  chk("Replay_Complete_ScbID", 32'(Replay_Complete_ScbID), 32'(m_saved));
      chk("Src1_Valid", 32'(Src1_Valid), e_empty ? 32'd0 : 32'(q[0].v1));
      chk("Src2_Valid", 32'(Src2_Valid), e_empty ? 32'd0 : 32'(q[0].v2));
      chk("Dst_Valid", 32'(Dst_Valid), e_empty ? 32'd0 : 32'(q[0].vd));
      if (!e_empty) begin
        chk("Src1", 32'(Src1), 32'(q[0].s1));
        chk("Src2", 32'(Src2), 32'(q[0].s2));
        chk("Dst", 32'(Dst), 32'(q[0].d));
        chk("Issue_Instr", Issue_Instr, q[0].instr);
      end
    end
  end

  always @(posedge clk) begin
    bit   mem_head, push_ok, do_pop;
    ent_t nv;
    if (!rst) begin
      q.delete();
      m_issued = 0;
      m_replay = 0;
      m_saved  = 0;
      m_live   = 1;
    end else begin
      model_eval();
      mem_head = (q.size() > 0) && q[0].mem;
      push_ok  = IF_Valid && (q.size() < DEPTH) && !Flush;
      do_pop   = (e_rpgrt && !mem_head) || e_rc;
      nv = '{IF_Instr, IF_Src1, IF_Src2, IF_Dst, IF_Src1_Valid, IF_Src2_Valid, IF_Dst_Valid, IF_IsMem};
      if (e_rpgrt && mem_head) begin
        m_issued = 1; m_replay = 0; m_saved = ScbID_Scb_IB;
      end else if (e_rc) begin
        m_issued = 0; m_replay = 0;
      end else if (m_issued && !m_replay && Mem_Replay) begin
        m_replay = 1;
      end else if (m_replay && e_grant) begin
        m_replay = 0;
      end
      if (do_pop) void'(q.pop_front());
      if (Flush) begin
        if (m_issued) while (q.size() > 1) void'(q.pop_back());
        else q.delete();
      end else if (push_ok) begin
        q.push_back(nv);
      end
    end
  end

  task automatic idle();
    IF_Valid = 0; IF_Instr = 0; IF_Src1 = 0; IF_Src2 = 0; IF_Dst = 0;
    IF_Src1_Valid = 0; IF_Src2_Valid = 0; IF_Dst_Valid = 0; IF_IsMem = 0;
    Scb_Dependent = 0; Scb_Full = 0; ScbID_Scb_IB = 0; Issue_Grt = 0;
    Mem_Replay = 0; Mem_Done = 0; Flush = 0;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic m);
    IF_Valid = 1; IF_Instr = ins; IF_Src1 = a; IF_Src2 = b; IF_Dst = d;
    IF_Src1_Valid = 1; IF_Src2_Valid = 1; IF_Dst_Valid = 1; IF_IsMem = m;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    tick();
    tick();
    rst = 1;
    #2;
    chk("lit reset Empty", 32'(Empty), 32'd1);
    chk("lit reset IF_Ready", 32'(IF_Ready), 32'd1);
    chk("lit reset Issue_Req", 32'(Issue_Req), 32'd0);
    chk("lit reset Src1_Valid", 32'(Src1_Valid), 32'd0);

    offer(32'h0000_00AD, 5'd3, 5'd4, 5'd5, 1'b0);
    #2 chk("lit no fallthrough", 32'(Src1_Valid), 32'd0);
    tick();
    #2;
    chk("lit head Src1", 32'(Src1), 32'd3);
    chk("lit head Src2", 32'(Src2), 32'd4);
    chk("lit head Dst", 32'(Dst), 32'd5);
    chk("lit head Dst_Valid", 32'(Dst_Valid), 32'd1);
    chk("lit add Issue_Req", 32'(Issue_Req), 32'd1);
    Issue_Grt = 1; ScbID_Scb_IB = 2;
    #2;
    chk("lit add RP_Grt", 32'(RP_Grt), 32'd1);
    chk("lit add Issue_ScbID", 32'(Issue_ScbID), 32'd2);
    tick();
    #2 chk("lit add popped", 32'(Empty), 32'd1);

    for (int i = 0; i < 4; i++) begin
      offer(32'h100 + 32'(i), 5'(i), 5'(i + 1), 5'(i + 2), 1'b0);
      tick();
    end
    #2 chk("lit full IF_Ready", 32'(IF_Ready), 32'd0);
    offer(32'hDEAD, 5'd9, 5'd9, 5'd9, 1'b0);
    tick();
    #2 chk("lit 5th dropped head", Issue_Instr, 32'h100);
    offer(32'hBEEF, 5'd9, 5'd9, 5'd9, 1'b0);
    Issue_Grt = 1;
    tick();
    #2;
    chk("lit pop at full IF_Ready", 32'(IF_Ready), 32'd1);
    chk("lit pop at full head", Issue_Instr, 32'h101);
    for (int i = 0; i < 3; i++) begin
      Issue_Grt = 1;
      tick();
    end
    #2 chk("lit drained", 32'(Empty), 32'd1);

    offer(32'h200, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    Scb_Dependent = 1;
    #2 chk("lit dependent", 32'(Issue_Req), 32'd0);
    Scb_Dependent = 0;
    #2 chk("lit dep cleared", 32'(Issue_Req), 32'd1);
    Scb_Full = 1;
    #2 chk("lit scb full", 32'(Issue_Req), 32'd0);
    Scb_Full = 0; Issue_Grt = 1;
    tick();

    offer(32'h300, 5'd6, 5'd7, 5'd8, 1'b1);
    tick();
    Issue_Grt = 1; ScbID_Scb_IB = 1;
    tick();
    #2 chk("lit wait no req", 32'(Issue_Req), 32'd0);
    Mem_Replay = 1;
    tick();
    Scb_Dependent = 1; Scb_Full = 1;
    #2;
    chk("lit replay req", 32'(Issue_Req), 32'd1);
    chk("lit replay flag", 32'(Issue_Replay), 32'd1);
    Issue_Grt = 1; ScbID_Scb_IB = 3;
    #2;
    chk("lit replay RP_Grt", 32'(RP_Grt), 32'd0);
    chk("lit replay ScbID", 32'(Issue_ScbID), 32'd1);
    tick();
    Mem_Done = 1;
    #2;
    chk("lit done", 32'(Replay_Complete), 32'd1);
    chk("lit done ScbID", 32'(Replay_Complete_ScbID), 32'd1);
    tick();
    #2 chk("lit done popped", 32'(Empty), 32'd1);

    for (int i = 0; i < 3; i++) begin
      offer(32'h400 + 32'(i), 5'(i), 5'(i), 5'(i), 1'b0);
      tick();
    end
    Flush = 1;
    tick();
    #2 chk("lit flush ready", 32'(Empty), 32'd1);
    offer(32'h500, 5'd1, 5'd1, 5'd1, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      offer(32'h501 + 32'(i), 5'd2, 5'd2, 5'd2, 1'b0);
      tick();
    end
    Issue_Grt = 1; ScbID_Scb_IB = 3;
    tick();
    Flush = 1;
    tick();
    #2 chk("lit flush keeps head", Issue_Instr, 32'h500);
    Mem_Done = 1;
    #2 chk("lit flush release id", 32'(Replay_Complete_ScbID), 32'd3);
    tick();
    #2 chk("lit flush count1", 32'(Empty), 32'd1);

    offer(32'h600, 5'd1, 5'd1, 5'd1, 1'b1);
    tick();
    Issue_Grt = 1; ScbID_Scb_IB = 0;
    tick();
    Mem_Done = 1; Mem_Replay = 1;
    tick();
    #2;
    chk("lit done wins empty", 32'(Empty), 32'd1);
    chk("lit done wins no req", 32'(Issue_Req), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      rst = (c != 1500);
      IF_Valid = 1'($urandom_range(0, 1));
      IF_Instr = $urandom;
      IF_Src1 = 5'($urandom); IF_Src2 = 5'($urandom); IF_Dst = 5'($urandom);
      IF_Src1_Valid = 1'($urandom_range(0, 1));
      IF_Src2_Valid = 1'($urandom_range(0, 1));
      IF_Dst_Valid = 1'($urandom_range(0, 1));
      IF_IsMem = ($urandom_range(0, 2) == 0);
      Scb_Dependent = ($urandom_range(0, 3) == 0);
      Scb_Full = ($urandom_range(0, 5) == 0);
      ScbID_Scb_IB = 2'($urandom);
      Issue_Grt = 1'($urandom_range(0, 1));
      Mem_Replay = ($urandom_range(0, 3) == 0);
      Mem_Done = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1;
    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ibuffer_warp.md
# ibuffer_warp

Per-warp instruction buffer between decode and the issue arbiter, directly upstream of the per-warp scoreboard. It queues decoded instructions in order and presents the head's register operands to the scoreboard. It requests issue only when the head is hazard-free and a scoreboard slot exists. It also tracks memory-instruction replays: it holds the head until the memory unit reports completion, then releases the scoreboard entry.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- INSTR_W, 32, raw instruction width carried alongside operands

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- IF_Valid  in  1  decoded instruction offered
- IF_Ready  out  1  buffer accepts (count < DEPTH)
- IF_Instr  in  INSTR_W  instruction word
- IF_Src1, IF_Src2, IF_Dst  in  5 each  register IDs
- IF_Src1_Valid, IF_Src2_Valid, IF_Dst_Valid  in  1 each  operand-used flags
- IF_IsMem  in  1  LW/SW (replayable)
- Src1, Src2, Dst  out  5 each  head operands to scoreboard
- Src1_Valid, Src2_Valid, Dst_Valid  out  1 each  head flags; forced 0 when buffer empty
- Scb_Dependent  in  1  hazard against head
- Scb_Full  in  1  no free scoreboard slot
- ScbID_Scb_IB  in  2  slot the scoreboard will allocate
- RP_Grt  out  1  allocate scoreboard entry (first issue only)
- Replay_Complete  out  1  release entry of completed memory instruction
- Replay_Complete_ScbID  out  2  slot being released
- Issue_Req  out  1  request to issue arbiter
- Issue_Replay  out  1  current request is a replay
- Issue_Grt  in  1  arbiter grant; only honoured while Issue_Req=1
- Issue_Instr  out  INSTR_W  head instruction
- Issue_ScbID  out  2  slot for this issue (new: ScbID_Scb_IB; replay: saved ID)
- Mem_Replay  in  1  memory unit rejects issued head; re-issue required
- Mem_Done  in  1  memory instruction finished
- Flush  in  1  discard unissued instructions (branch/exit)
- Empty  out  1  count == 0

## Operation
- Circular FIFO; rd_ptr, wr_ptr of log2(DEPTH) bits wrap naturally; count of log2(DEPTH)+1 bits.
- Push when IF_Valid & IF_Ready. Pop per head FSM below. Push and pop in the same cycle leave count unchanged.
- Head FSM, states H_READY, H_WAIT, H_REPLAY; reset and every pop return to H_READY.
- H_READY: Issue_Req = !Empty & !Scb_Dependent & !Scb_Full; Issue_Replay=0. On grant: RP_Grt=1, Issue_ScbID=ScbID_Scb_IB.
  - Non-mem head: pop.
  - Mem head: save ScbID into saved_id, go to H_WAIT, no pop.
- H_WAIT: Issue_Req=0.
  - Mem_Done: Replay_Complete=1, Replay_Complete_ScbID=saved_id, pop.
  - Mem_Replay: go to H_REPLAY.
  - Both asserted together: Mem_Done wins.
- H_REPLAY: Issue_Req=1, Issue_Replay=1. Scb_Dependent and Scb_Full are ignored, because the entry already exists and would self-conflict. On grant: RP_Grt=0, Issue_ScbID=saved_id, go to H_WAIT.
- Flush:
  - Head in H_READY: empty the buffer (rd_ptr=wr_ptr, count=0).
  - Head in H_WAIT/H_REPLAY: keep the head only (count=1, wr_ptr=rd_ptr+1). The scoreboard entry must still be released.
  - Flush overrides a same-cycle push. A same-cycle grant in H_READY is still honoured: RP_Grt pulses. A granted mem head is retained and enters H_WAIT.

## Timing
- Reset values:
  - count=0, FSM H_READY, IF_Ready=1, Empty=1.
  - Issue_Req, RP_Grt, Replay_Complete and Issue_Replay are all 0.
  - Operand valids are 0.
- Pushed instruction is visible at head (and to the scoreboard) the cycle after the push; there is no fall-through.
- Issue_Req, RP_Grt, Replay_Complete and Issue_ScbID are combinational in the same cycle as their causes. The pop and state change take effect at the next edge.
- IF_Ready is based on registered count only. A full buffer that pops does not accept in the same cycle.
- Minimum throughput: one non-mem issue per cycle when hazard-free.
- Mem instruction: ≥2 cycles from grant to pop (grant edge → H_WAIT, then Mem_Done).

## Test plan
- Reset, then push ADD(Src1=3, Src2=4, Dst=5) → next cycle head shows 3/4/5 with valids 1. With Scb_Dependent=0, Scb_Full=0 → Issue_Req=1. Grant with ScbID_Scb_IB=2 → RP_Grt=1, Issue_ScbID=2, Empty=1 next cycle.
- Push 4 instructions with no grants → IF_Ready=0 after the 4th. A 5th IF_Valid is not accepted. Grant+push in the same cycle at full → count stays 4 minus 1 → IF_Ready=1.
- Head with Scb_Dependent=1 → Issue_Req=0. Deassert → Issue_Req=1 in the same cycle. Scb_Full=1 → Issue_Req=0.
- LW granted with ScbID=1 → H_WAIT. Mem_Replay → Issue_Req=1, Issue_Replay=1 even with Scb_Dependent=1. Grant → RP_Grt=0, Issue_ScbID=1. Mem_Done → Replay_Complete=1, Replay_Complete_ScbID=1, head pops.
- Three queued, head in H_READY, Flush → Empty=1 next cycle. Repeat with mem head in H_WAIT → count=1. Mem_Done still releases the saved ID.
- Mem_Done and Mem_Replay in the same cycle → completion taken, pop, no replay request.
